me_frame_loader: RTL and testbench
==================================

// Module: me_frame_loader
// PURPOSE
//  Write-side front end for me_top: accepts an 8-bit pixel stream, fills the SW and TB
//  memory_single_port instances, raises req to me_top, and captures min_sad/min_mvec on ack.
//  Presents the captured result on a valid/ready port, then re-arms for the next frame.
//  Sits between an external byte source (UART/DMA) and the me_top + memories pair; owns mem mux.
// PARAMETERS
//  TB_LENGTH     16  template block edge (pixels)
//  SW_LENGTH     64  search window edge (pixels)
//  PE_OUT_WIDTH   8  PE output width, sets SAD width
//  derived: ADDR_SW=clog2(SW_LENGTH**2)=12, ADDR_TB=clog2(TB_LENGTH**2)=8,
//           CNT_WIDTH=clog2((SW_LENGTH-TB_LENGTH+1)**2)=12, SAD_WIDTH=clog2(TB_LENGTH**2)+PE_OUT_WIDTH=16
// PORTS
//  clk          in   1          single clock, all logic posedge
//  rst_n        in   1          asynchronous, active-low reset
//  s_valid      in   1          pixel stream valid
//  s_data       in   8          pixel byte, raster order: SW_LENGTH**2 SW bytes, then TB_LENGTH**2 TB bytes
//  s_ready      out  1          stream ready (high only in LOAD_SW/LOAD_TB)
//  me_addr_sw   in   ADDR_SW    me_top read address, passed through outside load states
//  me_addr_tb   in   ADDR_TB    me_top read address, passed through outside load states
//  mem_wren_sw  out  1          SW memory write enable
//  mem_addr_sw  out  ADDR_SW    SW memory address
//  mem_data_sw  out  8          SW memory write data
//  mem_wren_tb  out  1          TB memory write enable
//  mem_addr_tb  out  ADDR_TB    TB memory address
//  mem_data_tb  out  8          TB memory write data
//  me_req       out  1          request to me_top (level)
//  me_ack       in   1          done from me_top (level)
//  me_min_sad   in   SAD_WIDTH  me_top result SAD
//  me_min_mvec  in   CNT_WIDTH  me_top result vector index
//  res_valid    out  1          result valid
//  res_ready    in   1          result consumer ready
//  res_sad      out  SAD_WIDTH  captured min SAD
//  res_mvec     out  CNT_WIDTH  captured min vector
// BEHAVIOUR
//  FSM: IDLE -> LOAD_SW -> LOAD_TB -> RUN -> RELEASE -> RESULT -> LOAD_SW.
//  Reset: state=IDLE, load counter=0, me_req=0, res_valid=0, res_sad=0, res_mvec=0.
//   All mem_wren_* low in reset. IDLE -> LOAD_SW unconditionally on the first clk after release.
//  Accept = s_valid & s_ready. Write ports are combinational, zero latency:
//   mem_wren_x = accept in LOAD_x; mem_addr_x = load counter; mem_data_x = s_data.
//  Outside LOAD_x: mem_addr_x = me_addr_x; mem_wren_x = 0; mem_data_x = 0.
//  Load counter increments per accept only; s_valid gaps do not advance it.
//   LOAD_SW: on accept with cnt==SW_LENGTH**2-1, go to LOAD_TB, cnt=0.
//   LOAD_TB: on accept with cnt==TB_LENGTH**2-1, go to RUN, cnt=0, me_req<=1 (registered, high on first RUN cycle).
//  RUN: me_req held high. On me_ack==1: capture res_sad/res_mvec, me_req<=0, go to RELEASE.
//  RELEASE: me_req low; wait for me_ack==0, then res_valid<=1 and go to RESULT.
//  RESULT: res_valid high, res_sad/res_mvec stable. On res_ready: res_valid<=0, go to LOAD_SW.
//  me_ack high on RUN entry (stale): still treated as done. me_top is required to drop ack before RELEASE exit.
//  me_ack outside RUN/RELEASE: ignored. Stream bytes arriving outside load states: stall, s_ready=0.
//  rst_n asserted mid-operation: immediate return to reset values. No partial frame is resumed.
//   Memory contents are left as written; the next frame overwrites them.
//  No arithmetic beyond counter increment; counters are sized ADDR_SW wide and never wrap past the terminal value.
// STRUCTURE
//  Shared header me_params.vh: ADDR_SW/ADDR_TB/CNT_WIDTH/SAD_WIDTH derivations and FSM state encodings.
//   The same header is used by me_top and fpga_top.
//  Single flat module. No sub-module is warranted; the load counter and FSM are inline.
// TESTING (TB_LENGTH=4, SW_LENGTH=8 for speed, plus one run at defaults)
//  1. Reset, stream 64 SW bytes 0..63 then 16 TB bytes 100..115, s_valid always high
//     -> SW mem[i]=i and TB mem[j]=100+j. me_req rises the cycle after byte 80 accepted.
//  2. Same stream with s_valid toggling 1/0 each cycle
//     -> identical memory contents; no write occurs when s_valid=0.
//  3. me_top model raises ack 200 cycles after req with sad=16'h0123, mvec=12'd7
//     -> me_req falls next cycle. res_valid rises after ack low. res_sad=0x0123, res_mvec=7.
//  4. Hold res_ready=0 for 50 cycles in RESULT
//     -> res_valid and res_* stable, s_ready=0. After res_ready=1 for one cycle -> LOAD_SW, s_ready=1.
//  5. Assert rst_n=0 after 30 SW bytes
//     -> all outputs reset. Next full frame loads from address 0 correctly.
//  6. Model holds me_ack high 20 cycles after req drops
//     -> res_valid stays 0 until ack=0. Exactly one result is produced.

Source files
------------

// File: rtl/me_frame_loader_pkg.sv
// Shared types and helpers for the motion-estimation frame loader.
package me_frame_loader_pkg;

    localparam int PIX_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_SW,
        ST_LOAD_TB,
        ST_RUN,
        ST_RELEASE,
        ST_RESULT
    } state_t;

    // Pixel count of a square block with the given edge length.
    function automatic int unsigned block_pixels(input int unsigned edge_len);
        return edge_len * edge_len;
    endfunction

endpackage

// File: rtl/me_frame_loader.sv
// Write-side front end for me_top: loads SW/TB memories from a byte stream,
// hands the frame to me_top, and presents the captured result on valid/ready.
module me_frame_loader
    import me_frame_loader_pkg::*;
#(
    parameter int TB_LENGTH    = 16,
    parameter int SW_LENGTH    = 64,
    parameter int PE_OUT_WIDTH = 8,
    localparam int ADDR_SW   = $clog2(block_pixels(SW_LENGTH)),
    localparam int ADDR_TB   = $clog2(block_pixels(TB_LENGTH)),
    localparam int CNT_WIDTH = $clog2(block_pixels(SW_LENGTH - TB_LENGTH + 1)),
    localparam int SAD_WIDTH = $clog2(block_pixels(TB_LENGTH)) + PE_OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    input  logic [PIX_WIDTH-1:0] s_data,
    output logic                 s_ready,
    input  logic [ADDR_SW-1:0]   me_addr_sw,
    input  logic [ADDR_TB-1:0]   me_addr_tb,
    output logic                 mem_wren_sw,
    output logic [ADDR_SW-1:0]   mem_addr_sw,
    output logic [PIX_WIDTH-1:0] mem_data_sw,
    output logic                 mem_wren_tb,
    output logic [ADDR_TB-1:0]   mem_addr_tb,
    output logic [PIX_WIDTH-1:0] mem_data_tb,
    output logic                 me_req,
    input  logic                 me_ack,
    input  logic [SAD_WIDTH-1:0] me_min_sad,
    input  logic [CNT_WIDTH-1:0] me_min_mvec,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [SAD_WIDTH-1:0] res_sad,
    output logic [CNT_WIDTH-1:0] res_mvec
);

    localparam logic [ADDR_SW-1:0] SW_LAST = ADDR_SW'(block_pixels(SW_LENGTH) - 1);
    localparam logic [ADDR_SW-1:0] TB_LAST = ADDR_SW'(block_pixels(TB_LENGTH) - 1);

    state_t               state, state_n;
    logic [ADDR_SW-1:0]   cnt, cnt_n;
    logic                 me_req_n;
    logic                 res_valid_n;
    logic [SAD_WIDTH-1:0] res_sad_n;
    logic [CNT_WIDTH-1:0] res_mvec_n;
    logic                 accept;

    assign s_ready = (state == ST_LOAD_SW) || (state == ST_LOAD_TB);
    assign accept  = s_valid && s_ready;

    // State, load counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            me_req    <= 1'b0;
            res_valid <= 1'b0;
            res_sad   <= '0;
            res_mvec  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            me_req    <= me_req_n;
            res_valid <= res_valid_n;
            res_sad   <= res_sad_n;
            res_mvec  <= res_mvec_n;
        end
    end

    // Next-state logic: frame load, me_top handshake, result handoff.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        me_req_n    = me_req;
        res_valid_n = res_valid;
        res_sad_n   = res_sad;
        res_mvec_n  = res_mvec;
        case (state)
            ST_IDLE: state_n = ST_LOAD_SW;
            ST_LOAD_SW: begin
                if (accept) begin
                    if (cnt == SW_LAST) begin
                        cnt_n   = '0;
                        state_n = ST_LOAD_TB;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            ST_LOAD_TB: begin
                if (accept) begin
                    if (cnt == TB_LAST) begin
                        cnt_n    = '0;
                        me_req_n = 1'b1;
                        state_n  = ST_RUN;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (me_ack) begin
                    res_sad_n  = me_min_sad;
                    res_mvec_n = me_min_mvec;
                    me_req_n   = 1'b0;
                    state_n    = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!me_ack) begin
                    res_valid_n = 1'b1;
                    state_n     = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    res_valid_n = 1'b0;
                    state_n     = ST_LOAD_SW;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Memory port mux: stream writes while loading, me_top reads otherwise.
    always_comb begin
        mem_wren_sw = (state == ST_LOAD_SW) && accept;
        mem_addr_sw = (state == ST_LOAD_SW) ? cnt : me_addr_sw;
        mem_data_sw = (state == ST_LOAD_SW) ? s_data : '0;
        mem_wren_tb = (state == ST_LOAD_TB) && accept;
        mem_addr_tb = (state == ST_LOAD_TB) ? cnt[ADDR_TB-1:0] : me_addr_tb;
        mem_data_tb = (state == ST_LOAD_TB) ? s_data : '0;
    end

endmodule

// File: tb/tb_me_frame_loader.sv
// Self-checking bench for me_frame_loader with a reduced 8x8 window / 4x4 block.
module tb_me_frame_loader;

    localparam int TBL  = 4;
    localparam int SWL  = 8;
    localparam int NSW  = SWL * SWL;
    localparam int NTB  = TBL * TBL;
    localparam int ASW  = 6;
    localparam int ATB  = 4;
    localparam int CW   = 5;
    localparam int SADW = 12;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            s_valid = 1'b0;
    logic [7:0]      s_data = '0;
    logic            s_ready;
    logic [ASW-1:0]  me_addr_sw = '0;
    logic [ATB-1:0]  me_addr_tb = '0;
    logic            mem_wren_sw, mem_wren_tb;
    logic [ASW-1:0]  mem_addr_sw;
    logic [ATB-1:0]  mem_addr_tb;
    logic [7:0]      mem_data_sw, mem_data_tb;
    logic            me_req;
    logic            me_ack = 1'b0;
    logic [SADW-1:0] me_min_sad = '0;
    logic [CW-1:0]   me_min_mvec = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [SADW-1:0] res_sad;
    logic [CW-1:0]   res_mvec;

    me_frame_loader #(
        .TB_LENGTH    (TBL),
        .SW_LENGTH    (SWL),
        .PE_OUT_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .me_addr_sw  (me_addr_sw),
        .me_addr_tb  (me_addr_tb),
        .mem_wren_sw (mem_wren_sw),
        .mem_addr_sw (mem_addr_sw),
        .mem_data_sw (mem_data_sw),
        .mem_wren_tb (mem_wren_tb),
        .mem_addr_tb (mem_addr_tb),
        .mem_data_tb (mem_data_tb),
        .me_req      (me_req),
        .me_ack      (me_ack),
        .me_min_sad  (me_min_sad),
        .me_min_mvec (me_min_mvec),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sad     (res_sad),
        .res_mvec    (res_mvec)
    );

    always #5 clk = ~clk;

    // Memories driven by the DUT write ports, and the contents the stream should leave.
    logic [7:0] sw_mem [NSW];
    logic [7:0] tb_mem [NTB];
    logic [7:0] exp_sw [NSW];
    logic [7:0] exp_tb [NTB];

    always @(posedge clk) begin
        if (mem_wren_sw) sw_mem[mem_addr_sw] <= mem_data_sw;
        if (mem_wren_tb) tb_mem[mem_addr_tb] <= mem_data_tb;
    end

    int n_results = 0;
    int frames_done = 0;
    int n_vec = 0;
    int n_err = 0;

    always @(posedge clk) begin
        if (rst_n && res_valid && res_ready) n_results <= n_results + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; s_valid = 1'b0; me_ack = 1'b0; res_ready = 1'b0;
        #1;
        check_eq("rst_s_ready",   32'(s_ready),     32'd0);
        check_eq("rst_me_req",    32'(me_req),      32'd0);
        check_eq("rst_res_valid", 32'(res_valid),   32'd0);
        check_eq("rst_res_sad",   32'(res_sad),     32'd0);
        check_eq("rst_res_mvec",  32'(res_mvec),    32'd0);
        check_eq("rst_wren_sw",   32'(mem_wren_sw), 32'd0);
        check_eq("rst_wren_tb",   32'(mem_wren_tb), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("idle_s_ready", 32'(s_ready), 32'd0);
    endtask

    // mode 0: fixed pattern, valid always high; 1: fixed pattern, valid toggling;
    // 2: random bytes with random gaps. stop_at >= 0 abandons the frame early.
    task automatic send_frame(input int mode, input int stop_at);
        int gaps;
        logic [7:0] d;
        for (int idx = 0; idx < NSW + NTB; idx++) begin
            if (stop_at >= 0 && idx == stop_at) return;
            gaps = (mode == 1 && idx > 0) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (gaps) begin
                @(negedge clk);
                s_valid = 1'b0; s_data = 8'($urandom);
                #1;
                check_eq("gap_s_ready", 32'(s_ready),     32'd1);
                check_eq("gap_wren_sw", 32'(mem_wren_sw), 32'd0);
                check_eq("gap_wren_tb", 32'(mem_wren_tb), 32'd0);
            end
            if (mode == 2) d = 8'($urandom);
            else           d = (idx < NSW) ? 8'(idx) : 8'(100 + idx - NSW);
            @(negedge clk);
            s_valid = 1'b1; s_data = d;
            me_addr_sw = ASW'($urandom); me_addr_tb = ATB'($urandom);
            #1;
            check_eq("load_s_ready", 32'(s_ready), 32'd1);
            check_eq("load_me_req",  32'(me_req),  32'd0);
            if (idx < NSW) begin
                exp_sw[idx] = d;
                check_eq("sw_wren",      32'(mem_wren_sw), 32'd1);
                check_eq("sw_addr",      32'(mem_addr_sw), 32'(idx));
                check_eq("sw_data",      32'(mem_data_sw), 32'(d));
                check_eq("sw_tb_wren",   32'(mem_wren_tb), 32'd0);
                check_eq("sw_tb_pass",   32'(mem_addr_tb), 32'(me_addr_tb));
                check_eq("sw_tb_data",   32'(mem_data_tb), 32'd0);
            end else begin
                exp_tb[idx - NSW] = d;
                check_eq("tb_wren",      32'(mem_wren_tb), 32'd1);
                check_eq("tb_addr",      32'(mem_addr_tb), 32'(idx - NSW));
                check_eq("tb_data",      32'(mem_data_tb), 32'(d));
                check_eq("tb_sw_wren",   32'(mem_wren_sw), 32'd0);
                check_eq("tb_sw_pass",   32'(mem_addr_sw), 32'(me_addr_sw));
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        check_eq("req_rise",     32'(me_req),      32'd1);
        check_eq("run_s_ready",  32'(s_ready),     32'd0);
        check_eq("run_wren_sw",  32'(mem_wren_sw), 32'd0);
        check_eq("run_wren_tb",  32'(mem_wren_tb), 32'd0);
    endtask

    task automatic verify_mem();
        for (int i = 0; i < NSW; i++) check_eq("sw_mem", 32'(sw_mem[i]), 32'(exp_sw[i]));
        for (int i = 0; i < NTB; i++) check_eq("tb_mem", 32'(tb_mem[i]), 32'(exp_tb[i]));
    endtask

    task automatic run_result(input int ack_delay, input logic [SADW-1:0] sad,
                              input logic [CW-1:0] mv, input int ack_hold, input int ready_hold);
        repeat (ack_delay) begin
            @(negedge clk);
            me_addr_sw = ASW'($urandom); me_addr_tb = ATB'($urandom);
            #1;
            check_eq("run_req_held",  32'(me_req),      32'd1);
            check_eq("run_res_valid", 32'(res_valid),   32'd0);
            check_eq("run_sw_pass",   32'(mem_addr_sw), 32'(me_addr_sw));
            check_eq("run_tb_pass",   32'(mem_addr_tb), 32'(me_addr_tb));
            check_eq("run_sw_data",   32'(mem_data_sw), 32'd0);
        end
        me_ack = 1'b1; me_min_sad = sad; me_min_mvec = mv;
        @(negedge clk);
        #1;
        check_eq("req_fall",        32'(me_req),    32'd0);
        check_eq("rel_res_valid",   32'(res_valid), 32'd0);
        repeat (ack_hold) begin
            @(negedge clk);
            #1;
            check_eq("ackhold_valid", 32'(res_valid), 32'd0);
            check_eq("ackhold_req",   32'(me_req),    32'd0);
        end
        me_ack = 1'b0; me_min_sad = ~sad; me_min_mvec = ~mv;
        @(negedge clk);
        #1;
        check_eq("res_valid_rise", 32'(res_valid), 32'd1);
        check_eq("res_sad",        32'(res_sad),   32'(sad));
        check_eq("res_mvec",       32'(res_mvec),  32'(mv));
        check_eq("res_s_ready",    32'(s_ready),   32'd0);
        repeat (ready_hold) begin
            @(negedge clk);
            #1;
            check_eq("hold_valid",   32'(res_valid), 32'd1);
            check_eq("hold_sad",     32'(res_sad),   32'(sad));
            check_eq("hold_mvec",    32'(res_mvec),  32'(mv));
            check_eq("hold_s_ready", 32'(s_ready),   32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        check_eq("consume_valid",   32'(res_valid), 32'd0);
        check_eq("consume_s_ready", 32'(s_ready),   32'd1);
        frames_done++;
    endtask

    initial begin
        logic [SADW-1:0] sad;
        logic [CW-1:0]   mv;

        apply_reset();

        // Contiguous stream, slow me_top, consumer stalls 50 cycles.
        send_frame(0, -1);
        verify_mem();
        run_result(200, 12'h123, 5'd7, 0, 50);

        // Toggling valid, ack held high 20 cycles after req drops.
        send_frame(1, -1);
        verify_mem();
        run_result(int'($urandom_range(5, 30)), SADW'($urandom), CW'($urandom_range(0, 24)), 20, 3);

        // Stale ack already high before RUN; ignored during load.
        sad = SADW'($urandom); mv = CW'($urandom_range(0, 24));
        me_ack = 1'b1; me_min_sad = sad; me_min_mvec = mv;
        send_frame(2, -1);
        verify_mem();
        run_result(0, sad, mv, 2, 1);

        // Reset after 30 SW bytes, then a full frame from address 0.
        send_frame(2, 30);
        apply_reset();
        send_frame(0, -1);
        verify_mem();
        run_result(int'($urandom_range(1, 10)), SADW'($urandom), CW'($urandom_range(0, 24)), 1, 0);

        for (int f = 0; f < 2; f++) begin
            send_frame(2, -1);
            verify_mem();
            run_result(int'($urandom_range(0, 20)), SADW'($urandom), CW'($urandom_range(0, 24)),
                       int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
        end

        @(negedge clk);
        check_eq("result_count", 32'(n_results), 32'(frames_done));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
